prev_knn_scheduler: RTL and testbench

//  Sequences the K previous-query neighbours through the comparator for each new query point.

---
 rtl/prev_knn_scheduler.sv | 152 +++++++++++++++
 tb/tb_prev_knn_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prev_knn_scheduler.sv
// Purpose : walks the K previous-query neighbours through the comparator for each new query,
//           offers every comparator result to topK and refreshes the running mean at end of pass.
// Latency : 3 cycles per entry (READ, CAPT, SEND) plus one UPDATE cycle; start->done = 3K+1 cycles.
// Backpressure: SEND holds o_out_valid/o_out_entry stable until i_out_ready; no read is issued meanwhile.
//
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_start / o_busy / o_done pass control; start only honoured while idle, done pulses in UPDATE
//   o_rd_en, o_rd_idx, i_rd_data   prev-KNN buffer read port (data returns one cycle after o_rd_en)
//   o_cmp_entry, o_cmp_mean, i_cmp_result   external comparator (combinational)
//   o_out_valid, o_out_entry, i_out_ready   valid/ready stream to topK
//   i_mean_load, i_mean_in    running-mean override
//   o_running_mean, o_taken_count   current mean, entries forwarded with valid=1 this pass

package prev_knn_pkg;
    localparam int KNN_B = 32;

    typedef struct packed {
        logic             valid;
        logic [7:0]       id;
        logic [KNN_B-1:0] distance;
    } knn_entry_t;
endpackage

module prev_knn_scheduler
    import prev_knn_pkg::*;
#(
    parameter int          K         = 8,
    parameter int          LOG2_K    = 3,
    parameter int          B         = KNN_B,
    parameter logic [B-1:0] INIT_MEAN = {B{1'b1}}
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [LOG2_K-1:0] o_rd_idx,
    input  knn_entry_t        i_rd_data,
    output knn_entry_t        o_cmp_entry,
    output logic [B-1:0]      o_cmp_mean,
    input  knn_entry_t        i_cmp_result,
    output logic              o_out_valid,
    output knn_entry_t        o_out_entry,
    input  logic              i_out_ready,
    input  logic              i_mean_load,
    input  logic [B-1:0]      i_mean_in,
    output logic [B-1:0]      o_running_mean,
    output logic [LOG2_K:0]   o_taken_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_CAPT   = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    localparam logic [LOG2_K-1:0] IDX_LAST = LOG2_K'(K - 1);
    localparam logic [LOG2_K:0]   K_CNT    = (LOG2_K + 1)'(K);

    logic [2:0]          r_state;
    logic [LOG2_K-1:0]   r_idx;
    logic [B+LOG2_K-1:0] r_sum;
    logic [LOG2_K:0]     r_n_valid;
    logic [LOG2_K:0]     r_taken_count;
    logic [B-1:0]        r_running_mean;
    logic [B-1:0]        r_mean_snap;
    knn_entry_t          r_entry_q;

    logic                w_accept;
    logic [B-1:0]        w_avg;

    assign w_accept = (r_state == S_SEND) && i_out_ready;
    // Truncating divide by K: drop the low LOG2_K bits of the K-entry sum.
    assign w_avg    = r_sum[B+LOG2_K-1:LOG2_K];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_sum          <= '0;
            r_n_valid      <= '0;
            r_taken_count  <= '0;
            r_running_mean <= INIT_MEAN;
            r_mean_snap    <= INIT_MEAN;
            r_entry_q      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_idx         <= '0;
                        r_sum         <= '0;
                        r_n_valid     <= '0;
                        r_taken_count <= '0;
                        // Threshold is frozen here for the whole pass; a same-cycle override counts.
                        r_mean_snap   <= i_mean_load ? i_mean_in : r_running_mean;
                        r_state       <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_entry_q <= i_rd_data;
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    if (w_accept) begin
                        if (r_entry_q.valid) begin
                            r_sum     <= r_sum + (B + LOG2_K)'(r_entry_q.distance);
                            r_n_valid <= r_n_valid + 1'b1;
                        end
                        r_taken_count <= r_taken_count + (LOG2_K + 1)'(i_cmp_result.valid);
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_UPDATE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_UPDATE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Override always wins, including over the end-of-pass average.
            // The average is only trusted when every entry contributed a distance.
            if (i_mean_load) begin
                r_running_mean <= i_mean_in;
            end else if ((r_state == S_UPDATE) && (r_n_valid == K_CNT)) begin
                r_running_mean <= w_avg;
            end
        end
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_UPDATE);
    assign o_rd_en        = (r_state == S_READ);
    assign o_rd_idx       = r_idx;
    assign o_cmp_entry    = r_entry_q;
    assign o_cmp_mean     = r_mean_snap;
    assign o_out_valid    = (r_state == S_SEND);
    assign o_out_entry    = (r_state == S_SEND) ? i_cmp_result : '0;
    assign o_running_mean = r_running_mean;
    assign o_taken_count  = r_taken_count;

endmodule

// File: tb/tb_prev_knn_scheduler.sv
module tb_prev_knn_scheduler;
    import prev_knn_pkg::*;

    localparam int K = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, rd_en, out_valid, out_ready, mean_load;
    logic [2:0]  rd_idx;
    logic [31:0] cmp_mean, mean_in, running_mean;
    logic [3:0]  taken_count;
    knn_entry_t  rd_data, cmp_entry, cmp_result, out_entry;

    knn_entry_t  mem [K];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] model_mean;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Prev-KNN buffer: data appears one cycle after the read strobe.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_idx];

    // Comparator: keep the entry when distance <= mean (inclusive).
    always_comb begin
        cmp_result       = cmp_entry;
        cmp_result.valid = cmp_entry.valid && (cmp_entry.distance <= cmp_mean);
    end

    prev_knn_scheduler dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .o_busy(busy), .o_done(done),
        .o_rd_en(rd_en), .o_rd_idx(rd_idx), .i_rd_data(rd_data),
        .o_cmp_entry(cmp_entry), .o_cmp_mean(cmp_mean), .i_cmp_result(cmp_result),
        .o_out_valid(out_valid), .o_out_entry(out_entry), .i_out_ready(out_ready),
        .i_mean_load(mean_load), .i_mean_in(mean_in),
        .o_running_mean(running_mean), .o_taken_count(taken_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_seq(input logic [31:0] base, input int invalid_idx);
        for (int i = 0; i < K; i++) begin
            mem[i].valid    = (i != invalid_idx);
            mem[i].id       = 8'(i);
            mem[i].distance = base * 32'(i + 1);
        end
    endtask

    // One complete pass with an optional stall, an optional mean override at cycle
    // load_rel after start, and an optional ignored start pulse at busy_start_rel.
    task automatic run_pass(input string name, input int stall_at, input int stall_len,
                            input int load_rel, input logic [31:0] load_val,
                            input int busy_start_rel);
        knn_entry_t  exp_q [K];
        logic [31:0] snap;
        logic [31:0] m;
        logic [34:0] s;
        int          exp_taken;
        int          nval;
        int          t, rel, acc, stalled, done_rel;
        bit          seen_done;
        snap = model_mean;
        s = '0; nval = 0; exp_taken = 0; acc = 0; stalled = 0; seen_done = 0;
        done_rel = 3 * K + 1 + stall_len;
        for (int i = 0; i < K; i++) begin
            exp_q[i]       = mem[i];
            exp_q[i].valid = mem[i].valid && (mem[i].distance <= snap);
            if (exp_q[i].valid) exp_taken++;
            if (mem[i].valid) begin
                s = s + 35'(mem[i].distance);
                nval++;
            end
        end
        m = model_mean;
        if (load_rel >= 1 && load_rel < done_rel) m = load_val;
        if (nval == K) m = s[34:3];
        if (load_rel == done_rel) m = load_val;

        @(negedge clk);
        t = cyc; start = 1'b1; out_ready = 1'b1; mean_load = 1'b0;
        for (int c = 1; c <= 200 && !seen_done; c++) begin
            @(negedge clk);
            rel       = cyc - t;
            start     = (rel == busy_start_rel);
            mean_load = (rel == load_rel);
            mean_in   = load_val;
            check({name, "_busy"}, 64'(busy), 64'd1);
            if (rd_en) check({name, "_rd_idx"}, 64'(rd_idx), 64'(acc));
            if (out_valid) begin
                check({name, "_rd_en_in_send"}, 64'(rd_en), 64'd0);
                check({name, "_out_entry"}, 64'(out_entry), 64'(exp_q[acc]));
                if (acc == stall_at && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    acc++;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            if (done) begin
                seen_done = 1;
                check({name, "_done_cycle"}, 64'(rel), 64'(done_rel));
                check({name, "_taken_count"}, 64'(taken_count), 64'(exp_taken));
                check({name, "_accepted"}, 64'(acc), 64'(K));
            end
        end
        if (!seen_done) check({name, "_done_timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        start = 1'b0; mean_load = 1'b0; out_ready = 1'b1;
        check({name, "_running_mean"}, 64'(running_mean), 64'(m));
        check({name, "_idle_after"}, {62'd0, busy, done}, 64'd0);
        model_mean = m;
    endtask

    initial begin
        int acc;
        bit hit;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; mean_load = 1'b0; mean_in = '0;
        for (int i = 0; i < K; i++) mem[i] = '0;
        model_mean = 32'hFFFF_FFFF;

        // Reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_mean", 64'(running_mean), 64'hFFFF_FFFF);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_rd_en", 64'(rd_en), 64'd0);
        check("reset_taken", 64'(taken_count), 64'd0);

        // All valid, first pass takes everything; start while busy is ignored
        fill_seq(32'd10, -1);
        run_pass("p1_all", -1, 0, -1, '0, 5);
        // Same data against mean 45: only 10..40 survive
        run_pass("p2_thresh", -1, 0, -1, '0, -1);
        // Five stall cycles on entry 3
        run_pass("p3_stall", 3, 5, -1, '0, -1);
        // Invalid entry 2: mean must not move
        fill_seq(32'd10, 2);
        run_pass("p4_invalid", -1, 0, -1, '0, -1);
        // Mid-pass override: threshold stays 45, mean becomes 5 afterwards
        run_pass("p5_midload", -1, 0, 6, 32'd5, -1);
        // Override in UPDATE beats the computed average (45)
        fill_seq(32'd10, -1);
        run_pass("p6_updload", -1, 0, 3 * K + 1, 32'd5, -1);

        // Randomized passes
        for (int r = 0; r < 8; r++) begin
            int sa, sl, lr;
            for (int i = 0; i < K; i++) begin
                mem[i].valid    = ($urandom_range(0, 4) != 0);
                mem[i].id       = 8'($urandom_range(0, 255));
                mem[i].distance = 32'($urandom_range(0, 120));
            end
            sa = $urandom_range(0, K - 1);
            sl = $urandom_range(0, 4);
            lr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3 * K + 1 + sl) : -1;
            run_pass("rnd", sa, sl, lr, 32'($urandom_range(0, 120)), $urandom_range(2, 20));
        end

        // Reset during SEND of entry 4
        fill_seq(32'd7, -1);
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1; acc = 0; hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) begin
                if (acc == 4) begin
                    hit = 1;
                    rst = 1'b1;
                end else begin
                    acc++;
                end
            end
        end
        check("rst_reached_entry4", 64'(hit), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mean", 64'(running_mean), 64'hFFFF_FFFF);
        check("rst_taken", 64'(taken_count), 64'd0);
        hit = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) hit = 1;
        end
        check("rst_no_done_after", 64'(hit), 64'd0);
        model_mean = 32'hFFFF_FFFF;

        // Normal pass still works after abort
        run_pass("p7_after_rst", 1, 2, -1, '0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
